// File: rtl/alu_control_mc_pkg.sv
// alu_ctrl_pkg: aluop/funct/select codes, md_op encoding and MD sequencer states
package alu_ctrl_pkg;
    localparam logic [2:0] AOP_MEM    = 3'b000;
    localparam logic [2:0] AOP_BRANCH = 3'b001;
    localparam logic [2:0] AOP_RTYPE  = 3'b010;
    localparam logic [2:0] AOP_ANDI   = 3'b011;
    localparam logic [2:0] AOP_ORI    = 3'b100;
    localparam logic [2:0] AOP_SLTI   = 3'b101;
    localparam logic [2:0] AOP_LUI    = 3'b110;
    localparam logic [2:0] AOP_UNK    = 3'b111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        SEL_AND  = 4'b0000,
        SEL_OR   = 4'b0001,
        SEL_ADD  = 4'b0010,
        SEL_XOR  = 4'b0011,
        SEL_NOR  = 4'b0100,
        SEL_SUB  = 4'b0110,
        SEL_SLT  = 4'b0111,
        SEL_SLTU = 4'b1000,
        SEL_SLL  = 4'b1001,
        SEL_SRL  = 4'b1010,
        SEL_SRA  = 4'b1011,
        SEL_LUI  = 4'b1100,
        SEL_MFHI = 4'b1101,
        SEL_MFLO = 4'b1110,
        SEL_X    = 4'b1111
    } sel_e;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/alu_control_mc_if.sv
// alu_control_mc_if: decode-side request and ALU/MD control bundle of the ID/EX control stage
// master (pipeline) drives valid_in/aluop/funct/flush; slave (controller) drives
// valid_out/select/illegal/stall and the MD controls md_start/md_op/md_iter/busy/hilo_we
interface alu_control_mc_if #(
    parameter int MD_ITERS = 32,
    parameter int SEL_W    = 4,
    parameter int ALUOP_W  = 3
);
    localparam int IW = $clog2(MD_ITERS + 1);
    logic               valid_in;
    logic [ALUOP_W-1:0] aluop;
    logic [5:0]         funct;
    logic               flush;
    logic               valid_out;
    logic [SEL_W-1:0]   select;
    logic               illegal;
    logic               stall;
    logic               md_start;
    logic [1:0]         md_op;
    logic [IW-1:0]      md_iter;
    logic               busy;
    logic               hilo_we;
    modport master (
        output valid_in, aluop, funct, flush,
        input  valid_out, select, illegal, stall, md_start, md_op, md_iter, busy, hilo_we
    );
    modport slave (
        input  valid_in, aluop, funct, flush,
        output valid_out, select, illegal, stall, md_start, md_op, md_iter, busy, hilo_we
    );
endinterface

// File: rtl/alu_control_mc_decode.sv
// alu_decode: combinational aluop/funct -> {select, is_md, is_mfhilo, illegal} decoder
// inputs aluop, funct; outputs select code, MD-op flag, MFHI/MFLO flag, illegal R-type funct flag
module alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [5:0]         funct,
    output sel_e               select,
    output logic               is_md,
    output logic               is_mfhilo,
    output logic               illegal
);
    sel_e r_sel, a_sel;
    logic r_md, r_hilo, r_ill, rtype;
    always_comb begin
        r_sel  = SEL_X;
        r_md   = 1'b0;
        r_hilo = 1'b0;
        r_ill  = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU: r_sel = SEL_ADD;
            FN_SUB, FN_SUBU: r_sel = SEL_SUB;
            FN_AND:          r_sel = SEL_AND;
            FN_OR:           r_sel = SEL_OR;
            FN_XOR:          r_sel = SEL_XOR;
            FN_NOR:          r_sel = SEL_NOR;
            FN_SLT:          r_sel = SEL_SLT;
            FN_SLTU:         r_sel = SEL_SLTU;
            FN_SLL:          r_sel = SEL_SLL;
            FN_SRL:          r_sel = SEL_SRL;
            FN_SRA:          r_sel = SEL_SRA;
            FN_MFHI: begin
                r_sel  = SEL_MFHI;
                r_hilo = 1'b1;
            end
            FN_MFLO: begin
                r_sel  = SEL_MFLO;
                r_hilo = 1'b1;
            end
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r_md = 1'b1;
            default:                            r_ill = 1'b1;
        endcase
        a_sel = SEL_X;
        case (aluop)
            ALUOP_W'(AOP_MEM):    a_sel = SEL_ADD;
            ALUOP_W'(AOP_BRANCH): a_sel = SEL_SUB;
            ALUOP_W'(AOP_ANDI):   a_sel = SEL_AND;
            ALUOP_W'(AOP_ORI):    a_sel = SEL_OR;
            ALUOP_W'(AOP_SLTI):   a_sel = SEL_SLT;
            ALUOP_W'(AOP_LUI):    a_sel = SEL_LUI;
            ALUOP_W'(AOP_UNK):    a_sel = SEL_X;
            default:              a_sel = SEL_X;
        endcase
        rtype     = aluop == ALUOP_W'(AOP_RTYPE);
        select    = rtype ? r_sel : a_sel;
        is_md     = rtype && r_md;
        is_mfhilo = rtype && r_hilo;
        illegal   = rtype && r_ill;
    end
endmodule

// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU control decoder with iterative multiply/divide sequencer
// clk, rst (sync active-high); bus (slave modport): valid_in/aluop/funct/flush in,
// registered valid_out/select/illegal, combinational stall, MD controls md_start/md_op/md_iter/busy/hilo_we
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MD_ITERS = WIDTH,
    parameter int SEL_W    = 4,
    parameter int ALUOP_W  = 3
) (
    input logic             clk,
    input logic             rst,
    alu_control_mc_if.slave bus
);
    localparam int IW = $clog2(MD_ITERS + 1);

    sel_e             dec_sel;
    logic             dec_md, dec_hilo, dec_ill;
    state_e           state_q, state_d;
    logic [IW-1:0]    md_iter_q, md_iter_d;
    logic [SEL_W-1:0] select_q, select_d;
    md_op_e           md_op_q, md_op_d;
    logic             valid_out_q, valid_out_d;
    logic             illegal_q, illegal_d;
    logic             md_start_q, md_start_d;
    logic             hilo_we_q, hilo_we_d;
    logic             busy, stall, accept, last_iter;

    alu_decode #(.ALUOP_W(ALUOP_W)) u_dec (
        .aluop    (bus.aluop),
        .funct    (bus.funct),
        .select   (dec_sel),
        .is_md    (dec_md),
        .is_mfhilo(dec_hilo),
        .illegal  (dec_ill)
    );

    // Only instructions touching the MD unit or HI/LO wait for it; everything else overlaps.
    // hilo_we is registered off MD_DONE, so MFHI/MFLO accepted right after busy drops
    // reach EX one cycle after the HI/LO write.
    always_comb begin
        busy        = state_q != IDLE;
        stall       = bus.valid_in && busy && (dec_md || dec_hilo);
        accept      = bus.valid_in && !stall && !bus.flush;
        last_iter   = md_iter_q == IW'(MD_ITERS - 1);
        valid_out_d = accept;
        select_d    = accept ? SEL_W'(dec_sel) : select_q;
        illegal_d   = accept && dec_ill;
        md_start_d  = accept && dec_md;
        md_op_d     = md_start_d ? md_op_e'(bus.funct[1:0]) : md_op_q;
        hilo_we_d   = state_q == MD_DONE;
        state_d     = state_q == IDLE   ? (md_start_d ? MD_RUN : IDLE) :
                      state_q == MD_RUN ? (last_iter ? MD_DONE : MD_RUN) : IDLE;
        md_iter_d   = (state_q == MD_RUN && !last_iter) ? md_iter_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            md_iter_q   <= '0;
            select_q    <= '0;
            md_op_q     <= MD_MULT;
            valid_out_q <= 1'b0;
            illegal_q   <= 1'b0;
            md_start_q  <= 1'b0;
            hilo_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_iter_q   <= md_iter_d;
            select_q    <= select_d;
            md_op_q     <= md_op_d;
            valid_out_q <= valid_out_d;
            illegal_q   <= illegal_d;
            md_start_q  <= md_start_d;
            hilo_we_q   <= hilo_we_d;
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.select    = select_q;
    assign bus.illegal   = illegal_q;
    assign bus.stall     = stall;
    assign bus.md_start  = md_start_q;
    assign bus.md_op     = md_op_q;
    assign bus.md_iter   = md_iter_q;
    assign bus.busy      = busy;
    assign bus.hilo_we   = hilo_we_q;
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: vector table, directed MD sequences and random stimulus against a cycle-count reference model
module tb_alu_control_mc;
    localparam int MD_ITERS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_control_mc_if #(.MD_ITERS(MD_ITERS), .SEL_W(4), .ALUOP_W(3)) bus ();
    alu_control_mc #(.WIDTH(32), .MD_ITERS(MD_ITERS), .SEL_W(4), .ALUOP_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [2:0] aop;
        logic [5:0] fn;
        logic [3:0] sel;
        logic       ill;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit has_md = 0;
    int acc = 0;
    bit e_valid = 0;
    bit e_ill = 0;
    logic [3:0] e_sel = '0;
    logic [1:0] e_op = '0;
    logic [3:0] rmap [logic [5:0]];
    logic [3:0] amap [8] = '{4'h2, 4'h6, 4'hF, 4'h0, 4'h1, 4'h7, 4'hC, 4'hF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void ref_dec(input logic [2:0] aop, input logic [5:0] fn,
                                    output logic [3:0] sel, output bit md, output bit hl, output bit ill);
        md = 0;
        ill = 0;
        sel = amap[aop];
        if (aop == 3'b010) begin
            if (rmap.exists(fn)) sel = rmap[fn];
            else begin
                sel = 4'hF;
                if (fn[5:2] == 4'b0110) md = 1;
                else ill = 1;
            end
        end
        hl = aop == 3'b010 && (sel == 4'hD || sel == 4'hE);
    endfunction

    // One pipeline cycle: drive inputs, compare every output with the model, advance the model.
    task automatic tick(input bit v, input logic [2:0] aop, input logic [5:0] fn, input bit fl, input bit r);
        logic [3:0] s;
        bit md, hl, il, st, ac, bm;
        @(posedge clk);
        #1;
        cyc++;
        bus.valid_in = v;
        bus.aluop = aop;
        bus.funct = fn;
        bus.flush = fl;
        rst = r;
        @(negedge clk);
        ref_dec(aop, fn, s, md, hl, il);
        bm = has_md && cyc > acc && cyc <= acc + MD_ITERS + 1;
        st = v && bm && (md || hl);
        chk("valid_out", bus.valid_out, e_valid);
        chk("select", bus.select, e_sel);
        chk("illegal", bus.illegal, e_ill);
        chk("md_op", bus.md_op, e_op);
        chk("busy", bus.busy, bm);
        chk("stall", bus.stall, st);
        chk("md_start", bus.md_start, has_md && cyc == acc + 1);
        chk("hilo_we", bus.hilo_we, has_md && cyc == acc + MD_ITERS + 2);
        if (bm && cyc <= acc + MD_ITERS) chk("md_iter", bus.md_iter, cyc - acc - 1);
        ac = v && !st && !fl;
        if (r) begin
            e_valid = 0;
            e_ill = 0;
            e_sel = '0;
            e_op = '0;
            has_md = 0;
        end else begin
            e_valid = ac;
            e_ill = ac && il;
            if (ac) e_sel = s;
            if (ac && md) begin
                e_op = fn[1:0];
                has_md = 1;
                acc = cyc;
            end
        end
    endtask

    vec_t vt [22];
    logic [5:0] pool [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                              6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h3F};

    initial begin
        int t0, start_at, hilo_at, hilo_cnt, acc_at;
        logic [5:0] fn;
        logic [2:0] aop;
        rmap[6'h20] = 4'h2; rmap[6'h21] = 4'h2; rmap[6'h22] = 4'h6; rmap[6'h23] = 4'h6;
        rmap[6'h24] = 4'h0; rmap[6'h25] = 4'h1; rmap[6'h26] = 4'h3; rmap[6'h27] = 4'h4;
        rmap[6'h2A] = 4'h7; rmap[6'h2B] = 4'h8; rmap[6'h00] = 4'h9; rmap[6'h02] = 4'hA;
        rmap[6'h03] = 4'hB; rmap[6'h10] = 4'hD; rmap[6'h12] = 4'hE;
        vt[0]  = '{3'b010, 6'b100111, 4'b0100, 1'b0};
        vt[1]  = '{3'b010, 6'b111111, 4'b1111, 1'b1};
        vt[2]  = '{3'b010, 6'b100000, 4'b0010, 1'b0};
        vt[3]  = '{3'b010, 6'b100011, 4'b0110, 1'b0};
        vt[4]  = '{3'b010, 6'b100110, 4'b0011, 1'b0};
        vt[5]  = '{3'b010, 6'b101011, 4'b1000, 1'b0};
        vt[6]  = '{3'b010, 6'b000011, 4'b1011, 1'b0};
        vt[7]  = '{3'b010, 6'b000010, 4'b1010, 1'b0};
        vt[8]  = '{3'b010, 6'b000000, 4'b1001, 1'b0};
        vt[9]  = '{3'b010, 6'b101010, 4'b0111, 1'b0};
        vt[10] = '{3'b010, 6'b010000, 4'b1101, 1'b0};
        vt[11] = '{3'b010, 6'b010010, 4'b1110, 1'b0};
        vt[12] = '{3'b000, 6'b011000, 4'b0010, 1'b0};
        vt[13] = '{3'b110, 6'b000000, 4'b1100, 1'b0};
        vt[14] = '{3'b111, 6'b100000, 4'b1111, 1'b0};
        vt[15] = '{3'b101, 6'b111111, 4'b0111, 1'b0};
        vt[16] = '{3'b011, 6'b000000, 4'b0000, 1'b0};
        vt[17] = '{3'b100, 6'b000000, 4'b0001, 1'b0};
        vt[18] = '{3'b001, 6'b000000, 4'b0110, 1'b0};
        vt[19] = '{3'b010, 6'b100101, 4'b0001, 1'b0};
        vt[20] = '{3'b010, 6'b100100, 4'b0000, 1'b0};
        vt[21] = '{3'b010, 6'b000001, 4'b1111, 1'b1};
        bus.valid_in = 0;
        bus.aluop = '0;
        bus.funct = '0;
        bus.flush = 0;
        repeat (2) @(posedge clk);
        tick(0, 3'b000, 6'h00, 0, 1);
        chk("rst_select", bus.select, 4'h0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_md_iter", bus.md_iter, 0);

        foreach (vt[i]) begin
            tick(1, vt[i].aop, vt[i].fn, 0, 0);
            tick(0, 3'b000, 6'h00, 0, 0);
            chk("tbl_valid", bus.valid_out, 1);
            chk("tbl_select", bus.select, vt[i].sel);
            chk("tbl_illegal", bus.illegal, vt[i].ill);
        end
        tick(0, 3'b000, 6'h00, 0, 0);
        chk("illegal_pulse_end", bus.illegal, 0);

        tick(1, 3'b010, 6'b011000, 0, 0);
        t0 = cyc; start_at = -1; hilo_at = -1; hilo_cnt = 0;
        repeat (40) begin
            tick(0, 3'b000, 6'h00, 0, 0);
            if (bus.md_start) start_at = cyc - t0;
            if (bus.hilo_we) begin hilo_cnt++; hilo_at = cyc - t0; end
        end
        chk("mult_start_lat", start_at, 1);
        chk("mult_hilo_lat", hilo_at, MD_ITERS + 2);
        chk("mult_hilo_cnt", hilo_cnt, 1);
        chk("mult_op", bus.md_op, 2'b00);

        tick(1, 3'b010, 6'b011001, 0, 0);
        t0 = cyc;
        tick(1, 3'b010, 6'b100000, 0, 0);
        chk("add_no_stall", bus.stall, 0);
        acc_at = -1;
        for (int i = 0; i < 40 && acc_at < 0; i++) begin
            tick(1, 3'b010, 6'b010010, 0, 0);
            if (!bus.stall) acc_at = cyc - t0;
        end
        chk("mflo_accept_lat", acc_at, MD_ITERS + 2);
        tick(0, 3'b000, 6'h00, 0, 0);
        chk("mflo_select", bus.select, 4'b1110);
        chk("multu_op", bus.md_op, 2'b01);

        tick(1, 3'b010, 6'b011010, 1, 0);
        start_at = 0;
        repeat (4) begin
            tick(0, 3'b000, 6'h00, 0, 0);
            if (bus.md_start) start_at++;
        end
        chk("flush_div_busy", bus.busy, 0);
        chk("flush_div_start", start_at, 0);
        chk("flush_div_op", bus.md_op, 2'b01);

        tick(1, 3'b010, 6'b011011, 0, 0);
        t0 = cyc; hilo_at = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i >= 5 && i <= 8) tick(1, 3'b010, (i[0] ? 6'b100000 : 6'b011011), 1, 0);
            else tick(0, 3'b000, 6'h00, 0, 0);
            if (bus.hilo_we) hilo_at = cyc - t0;
        end
        chk("flush_run_hilo_lat", hilo_at, MD_ITERS + 2);
        chk("divu_op", bus.md_op, 2'b11);

        tick(1, 3'b010, 6'b011000, 0, 0);
        repeat (10) tick(0, 3'b000, 6'h00, 0, 0);
        tick(0, 3'b000, 6'h00, 0, 1);
        chk("iter_at_rst", bus.md_iter, 10);
        tick(0, 3'b000, 6'h00, 0, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_iter", bus.md_iter, 0);
        hilo_cnt = 0;
        repeat (40) begin
            tick(0, 3'b000, 6'h00, 0, 0);
            if (bus.hilo_we) hilo_cnt++;
        end
        chk("rst_mid_no_hilo", hilo_cnt, 0);

        for (int n = 0; n < 3000; n++) begin
            aop = $urandom_range(0, 1) ? 3'b010 : 3'($urandom_range(0, 7));
            fn = $urandom_range(0, 9) == 0 ? 6'($urandom) : pool[$urandom_range(0, 19)];
            tick($urandom_range(0, 9) < 7, aop, fn, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
        end
        tick(0, 3'b000, 6'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
